// File: rtl/riscv_muldiv_pkg.sv
// Shared types and constants for the RV32M iterative multiply/divide unit.
//   muldiv_op_e    : funct3 encoding of the M-extension operations
//   muldiv_state_e : control FSM states
//   DIV0_QUOT      : fill bit of the quotient returned for a divide by zero (all ones)
//   REM_OVF        : fill bit of the remainder returned for signed overflow (all zeros)
package riscv_muldiv_pkg;

  typedef enum logic [2:0] {
    OP_MUL    = 3'd0,
    OP_MULH   = 3'd1,
    OP_MULHSU = 3'd2,
    OP_MULHU  = 3'd3,
    OP_DIV    = 3'd4,
    OP_DIVU   = 3'd5,
    OP_REM    = 3'd6,
    OP_REMU   = 3'd7
  } muldiv_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } muldiv_state_e;

  localparam logic DIV0_QUOT = 1'b1;
  localparam logic REM_OVF   = 1'b0;

  // Operand A is treated as signed for MUL, MULH, MULHSU, DIV and REM.
  // MUL's low half does not depend on signedness, so either choice is correct there.
  function automatic logic op_a_signed(input muldiv_op_e op);
    return (op == OP_MUL) || (op == OP_MULH) || (op == OP_MULHSU) ||
           (op == OP_DIV) || (op == OP_REM);
  endfunction

  // Operand B is signed for MUL, MULH, DIV and REM (MULHSU takes B unsigned).
  function automatic logic op_b_signed(input muldiv_op_e op);
    return (op == OP_MUL) || (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
  endfunction

endpackage

// File: rtl/riscv_muldiv_unit_if.sv
// Request / register-file-write bundle between the core and the mul/div unit.
//   master : core side (drives request, flush; observes busy and the RF write)
//   slave  : unit side
// Signals: start_i, funct3_i, rs1_data_i, rs2_data_i, rd_addr_i, kill_i,
//          busy_o, rf_we_o, rf_waddr_o, rf_wdata_o
interface riscv_muldiv_unit_if #(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned RF_DEPTH = 32
);
  localparam int unsigned RD_W = $clog2(RF_DEPTH);

  logic            start_i;
  logic [2:0]      funct3_i;
  logic [XLEN-1:0] rs1_data_i;
  logic [XLEN-1:0] rs2_data_i;
  logic [RD_W-1:0] rd_addr_i;
  logic            kill_i;
  logic            busy_o;
  logic            rf_we_o;
  logic [RD_W-1:0] rf_waddr_o;
  logic [XLEN-1:0] rf_wdata_o;

  modport master (
    output start_i, funct3_i, rs1_data_i, rs2_data_i, rd_addr_i, kill_i,
    input  busy_o, rf_we_o, rf_waddr_o, rf_wdata_o
  );

  modport slave (
    input  start_i, funct3_i, rs1_data_i, rs2_data_i, rd_addr_i, kill_i,
    output busy_o, rf_we_o, rf_waddr_o, rf_wdata_o
  );
endinterface

// File: rtl/muldiv_sign_fix.sv
// Conditional two's-complement negate: absolute value at accept, sign fix-up at DONE.
//   val_i : input value, neg_i : negate when high, val_o : result (combinational)
module muldiv_sign_fix #(
  parameter int unsigned W = 32
) (
  input  logic [W-1:0] val_i,
  input  logic         neg_i,
  output logic [W-1:0] val_o
);
  assign val_o = neg_i ? (~val_i + W'(1)) : val_i;
endmodule

// File: rtl/riscv_muldiv_unit.sv
// Iterative RV32M multiply/divide unit: one multiplier/quotient bit per cycle on
// operand magnitudes, sign-corrected in DONE, then a single register-file write.
// Ports:
//   clk_i : clock, rising edge
//   rst_i : asynchronous active-high reset
//   bus   : riscv_muldiv_unit_if.slave (request, flush, busy, RF write port)
// Build option: MULDIV_FAST_MUL_EN selects a single-cycle multiplier (IDLE -> DONE);
// the divide path is unaffected.
module riscv_muldiv_unit
  import riscv_muldiv_pkg::*;
#(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned RF_DEPTH = 32
) (
  input logic                 clk_i,
  input logic                 rst_i,
  riscv_muldiv_unit_if.slave  bus
);

  localparam int unsigned RD_W  = $clog2(RF_DEPTH);
  localparam int unsigned CNT_W = $clog2(XLEN);

  muldiv_state_e   state_q, state_d;
  muldiv_op_e      op_q, op_d;
  logic [RD_W-1:0] rd_q, rd_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  // opnd: multiplicand magnitude (mul) or divisor magnitude (div)
  logic [XLEN-1:0] opnd_q, opnd_d;
  // {hi,lo}: product accumulator (mul) or {remainder, dividend/quotient} (div)
  logic [XLEN-1:0] hi_q, hi_d, lo_q, lo_d;
  logic            qneg_q, qneg_d, rneg_q, rneg_d;
  logic            busy_q, busy_d, we_q, we_d;
  logic [RD_W-1:0] waddr_q, waddr_d;
  logic [XLEN-1:0] wdata_q, wdata_d;

  // Request decode and operand magnitudes
  muldiv_op_e      req_op;
  logic            a_neg, b_neg, div_zero, div_ovf;
  logic [XLEN-1:0] abs_a, abs_b;

  assign req_op   = muldiv_op_e'(bus.funct3_i);
  assign a_neg    = op_a_signed(req_op) & bus.rs1_data_i[XLEN-1];
  assign b_neg    = op_b_signed(req_op) & bus.rs2_data_i[XLEN-1];
  assign div_zero = (bus.rs2_data_i == '0);
  assign div_ovf  = ((req_op == OP_DIV) || (req_op == OP_REM)) &&
                    (bus.rs1_data_i == {1'b1, {(XLEN-1){1'b0}}}) &&
                    (bus.rs2_data_i == '1);

  muldiv_sign_fix #(.W(XLEN)) u_abs_a (.val_i(bus.rs1_data_i), .neg_i(a_neg), .val_o(abs_a));
  muldiv_sign_fix #(.W(XLEN)) u_abs_b (.val_i(bus.rs2_data_i), .neg_i(b_neg), .val_o(abs_b));

`ifdef MULDIV_FAST_MUL_EN
  // Sign-extending both operands to 2*XLEN yields the low 2*XLEN bits of the
  // (XLEN+1)x(XLEN+1) signed product, which is all the result mux needs.
  logic [2*XLEN-1:0] fast_a, fast_b, fast_prod;
  assign fast_a    = {{XLEN{a_neg}}, bus.rs1_data_i};
  assign fast_b    = {{XLEN{b_neg}}, bus.rs2_data_i};
  assign fast_prod = fast_a * fast_b;
`endif

  // One shift-add step: conditionally add multiplicand, shift {carry,hi,lo} right
  logic [XLEN:0] mul_sum;
  assign mul_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);

  // One restoring step: borrow out in bit XLEN means the trial subtract failed
  logic [XLEN:0] div_shift, div_diff;
  assign div_shift = {hi_q, lo_q[XLEN-1]};
  assign div_diff  = div_shift - {1'b0, opnd_q};

  // Final sign fix-up
  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   quot_fix, rem_fix, result;

  muldiv_sign_fix #(.W(2*XLEN)) u_fix_prod (.val_i({hi_q, lo_q}), .neg_i(qneg_q), .val_o(prod_fix));
  muldiv_sign_fix #(.W(XLEN))   u_fix_quot (.val_i(lo_q), .neg_i(qneg_q), .val_o(quot_fix));
  muldiv_sign_fix #(.W(XLEN))   u_fix_rem  (.val_i(hi_q), .neg_i(rneg_q), .val_o(rem_fix));

  always_comb begin
    result = rem_fix;
    case (op_q)
      OP_MUL:                       result = prod_fix[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: result = prod_fix[2*XLEN-1:XLEN];
      OP_DIV, OP_DIVU:              result = quot_fix;
      default:                      result = rem_fix;
    endcase
  end

  // Next-state, datapath and registered-output logic
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    rd_d    = rd_q;
    cnt_d   = cnt_q;
    opnd_d  = opnd_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
    we_d    = 1'b0;
    waddr_d = waddr_q;
    wdata_d = wdata_q;

    case (state_q)
      ST_IDLE: begin
        if (bus.start_i && !bus.kill_i) begin
          op_d  = req_op;
          rd_d  = bus.rd_addr_i;
          cnt_d = '0;
          hi_d  = '0;
          if (req_op[2]) begin
            opnd_d  = abs_b;
            lo_d    = abs_a;
            qneg_d  = a_neg ^ b_neg;
            rneg_d  = a_neg;
            state_d = ST_CALC;
            // Special cases skip iteration; results preloaded unsigned-correct
            if (div_zero) begin
              lo_d    = {XLEN{DIV0_QUOT}};
              hi_d    = bus.rs1_data_i;
              qneg_d  = 1'b0;
              rneg_d  = 1'b0;
              state_d = ST_DONE;
            end else if (div_ovf) begin
              lo_d    = bus.rs1_data_i;
              hi_d    = {XLEN{REM_OVF}};
              qneg_d  = 1'b0;
              rneg_d  = 1'b0;
              state_d = ST_DONE;
            end
          end else begin
`ifdef MULDIV_FAST_MUL_EN
            {hi_d, lo_d} = fast_prod;
            qneg_d  = 1'b0;
            rneg_d  = 1'b0;
            state_d = ST_DONE;
`else
            opnd_d  = abs_a;
            lo_d    = abs_b;
            qneg_d  = a_neg ^ b_neg;
            rneg_d  = 1'b0;
            state_d = ST_CALC;
`endif
          end
        end
      end
      ST_CALC: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (op_q[2]) begin
          if (!div_diff[XLEN]) begin
            hi_d = div_diff[XLEN-1:0];
            lo_d = {lo_q[XLEN-2:0], 1'b1};
          end else begin
            hi_d = div_shift[XLEN-1:0];
            lo_d = {lo_q[XLEN-2:0], 1'b0};
          end
        end else begin
          hi_d = mul_sum[XLEN:1];
          lo_d = {mul_sum[0], lo_q[XLEN-1:1]};
        end
        if (cnt_q == CNT_W'(XLEN-1)) state_d = ST_DONE;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        // x0 is hard-wired to zero: complete the op but never write it
        if (rd_q != '0) begin
          we_d    = 1'b1;
          waddr_d = rd_q;
          wdata_d = result;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Flush wins over everything, including a write about to issue
    if (bus.kill_i) begin
      state_d = ST_IDLE;
      we_d    = 1'b0;
      waddr_d = waddr_q;
      wdata_d = wdata_q;
    end

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      op_q    <= OP_MUL;
      rd_q    <= '0;
      cnt_q   <= '0;
      opnd_q  <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      busy_q  <= 1'b0;
      we_q    <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      rd_q    <= rd_d;
      cnt_q   <= cnt_d;
      opnd_q  <= opnd_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
      busy_q  <= busy_d;
      we_q    <= we_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
    end
  end

  assign bus.busy_o     = busy_q;
  assign bus.rf_we_o    = we_q;
  assign bus.rf_waddr_o = waddr_q;
  assign bus.rf_wdata_o = wdata_q;

endmodule
